stage_sched: RTL and testbench
==============================

Name: stage_sched

Overview:
- Programmable stage scheduler that drives the EKF-SLAM Top `stage_val`/`stage_rdy` handshake in hardware. It replaces hand-timed stimulus.
- Holds a table of up to SEQ_DEPTH stage codes: IDLE=0, PRD=1, NEW=2, UPD=3, ASSOC=4.
- Issues each code as a fixed-length pulse, waits for Top completion or timeout, then advances. Repeats the table N times or loops until abort.
- Sits between the host/config side and Top.

Parameters:
- STAGE_W, 3, stage code width.
- SEQ_DEPTH, 8, table entries.
- SEQ_AW, 3, table address width (clog2 SEQ_DEPTH).
- PULSE_LEN, 2, cycles `stage_val` is held non-zero per issue (≥1).
- TMO_W, 16, timeout counter width.
- ITER_W, 8, iteration counter width.

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  asynchronous active-high reset.
- cfg_we  in  1  table write strobe; ignored while busy.
- cfg_addr  in  SEQ_AW  table write address.
- cfg_stage  in  STAGE_W  stage code written.
- seq_len  in  SEQ_AW+1  entries per pass (0..SEQ_DEPTH); sampled at start.
- iter_num  in  ITER_W  passes to run; 0 treated as 1; sampled at start.
- loop_en  in  1  1 = repeat passes until abort; sampled at start.
- timeout_cyc  in  TMO_W  max WAIT cycles per stage; 0 = no timeout; sampled at start.
- start  in  1  begin run; honoured only in IDLE.
- abort  in  1  terminate run.
- stage_rdy  in  STAGE_W  Top completion code.
- stage_val  out  STAGE_W  stage issue to Top, registered.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- err_timeout  out  1  sticky; set on timeout, cleared on next accepted start.
- cur_idx  out  SEQ_AW  table index being executed.
- iter_cnt  out  ITER_W  completed passes.

Behaviour:
Reset: all outputs 0; state IDLE; table contents cleared to 0.

Table writes:
- `cfg_we` in IDLE writes `cfg_stage` to `table[cfg_addr]` on the clock edge.
- `cfg_we` outside IDLE is dropped.

States:
- IDLE: `busy`=0. `start`=1 latches config, clears `cur_idx`, `iter_cnt` and `err_timeout`, then goes to FETCH. With `seq_len`=0 it goes to FIN instead.
- FETCH (1 cycle): reads `table[cur_idx]`. Code 0 → NEXT (skip entry). Otherwise → ISSUE with `stage_val` registered to the code.
- ISSUE: `stage_val` held for exactly PULSE_LEN cycles, then set to 0 → WAIT. First `stage_val` is visible on the 2nd rising edge after the edge that samples `start`.
- WAIT: timeout counter counts from 0 on entry.
  - Completion → NEXT.
  - Counter reaching `timeout_cyc` (when non-zero) → sets `err_timeout` → FIN.
- NEXT: if `cur_idx` = `seq_len`−1:
  - increment `iter_cnt`, wrap `cur_idx` to 0;
  - go to FIN when `loop_en`=0 and `iter_cnt`+1 ≥ max(`iter_num`,1);
  - otherwise go to FETCH.
  If `cur_idx` < `seq_len`−1: increment `cur_idx` → FETCH.
- FIN: `done`=1 for one cycle → IDLE. `busy`=0 from the next cycle. `cur_idx` and `iter_cnt` hold their final values.

Completion detection:
- Completion = rising match: `stage_rdy` == issued code this cycle, and `stage_rdy` != issued code on the previous cycle.
- Monitored during ISSUE and WAIT. A match during ISSUE is latched and consumed on WAIT entry (WAIT lasts 1 cycle).
- A level already matching at issue time does not count; the edge history is reset at FETCH.

Abort:
- `abort`=1 in any non-IDLE state → next edge: `stage_val`=0, state FIN, `done` pulse.
- `err_timeout` is unchanged by abort.
- `abort` has priority over completion and timeout in the same cycle.

Simultaneous events:
- `start` and `abort` together in IDLE: `start` ignored.
- Completion and timeout in the same WAIT cycle: completion wins.

Async reset mid-run: immediate return to IDLE, `stage_val`=0, no `done` pulse.

Counters: `cur_idx` and `iter_cnt` do not saturate. In loop mode `iter_cnt` wraps modulo 2^ITER_W with no error.

Test Plan:
- Table [1,2,3,4], `seq_len`=4, `iter_num`=1, `timeout_cyc`=0; Top model returns matching `stage_rdy` 600 cycles after each issue → exactly four 2-cycle pulses 1,2,3,4 in order; one `done`; `iter_cnt`=1; `err_timeout`=0.
- Table [4], `timeout_cyc`=100, Top never responds → `stage_val`=4 for 2 cycles; `err_timeout`=1 and `done` pulse 100 cycles after WAIT entry; `busy`=0 after; next `start` clears `err_timeout`.
- Table [1,0,2], `seq_len`=3, `iter_num`=3 → 0 entry never issued; sequence 1,2 repeated three times; `iter_cnt`=3; one `done`.
- `loop_en`=1, table [3], `abort` asserted during WAIT of the 5th issue → `stage_val` 0, `done` next cycle, `iter_cnt`=4; `cfg_we` during the run has no effect on table readback in the next run.
- `stage_rdy` held at 2 before issuing code 2 → no premature completion; `stage_rdy` drop to 0 then back to 2 → advance. Completion arriving during ISSUE (PULSE_LEN=2) → advance after a 1-cycle WAIT.
- `sys_rst` pulsed mid-ISSUE → all outputs 0 immediately; no `done`; `seq_len`=0 `start` after reset → `done` 2 cycles after `start`, no `stage_val` activity.

Source files
------------

// File: rtl/stage_sched.sv
// stage_sched: programmable stage sequencer driving the EKF-SLAM Top
// stage_val/stage_rdy handshake. A small table of stage codes is issued
// entry by entry as fixed-length pulses. After each pulse the block waits
// for Top to acknowledge or for a timeout. The table is run for a number
// of passes, or repeated until abort.
module stage_sched #(
  parameter int STAGE_W   = 3,
  parameter int SEQ_DEPTH = 8,
  parameter int SEQ_AW    = 3,
  parameter int PULSE_LEN = 2,
  parameter int TMO_W     = 16,
  parameter int ITER_W    = 8
) (
  input  logic               clk,
  input  logic               sys_rst,
  input  logic               cfg_we,
  input  logic [SEQ_AW-1:0]  cfg_addr,
  input  logic [STAGE_W-1:0] cfg_stage,
  input  logic [SEQ_AW:0]    seq_len,
  input  logic [ITER_W-1:0]  iter_num,
  input  logic               loop_en,
  input  logic [TMO_W-1:0]   timeout_cyc,
  input  logic               start,
  input  logic               abort,
  input  logic [STAGE_W-1:0] stage_rdy,
  output logic [STAGE_W-1:0] stage_val,
  output logic               busy,
  output logic               done,
  output logic               err_timeout,
  output logic [SEQ_AW-1:0]  cur_idx,
  output logic [ITER_W-1:0]  iter_cnt
);

  localparam int PCNT_W = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_NEXT, S_FIN
  } state_t;

  state_t               state_q;
  logic [STAGE_W-1:0]   table_q [SEQ_DEPTH];
  logic [STAGE_W-1:0]   stage_val_q;
  logic [STAGE_W-1:0]   code_q;        // code currently issued / awaited
  logic                 busy_q;
  logic                 done_q;
  logic                 err_q;
  logic [SEQ_AW-1:0]    idx_q;
  logic [ITER_W-1:0]    iter_q;
  logic [SEQ_AW:0]      len_q;         // run configuration captured at start
  logic [ITER_W-1:0]    iter_num_q;
  logic                 loop_q;
  logic [TMO_W-1:0]     tmo_q;
  logic [TMO_W-1:0]     wcnt_q;        // cycles spent in WAIT
  logic [PCNT_W-1:0]    pcnt_q;        // cycles spent in ISSUE
  logic                 prev_match_q;  // stage_rdy matched code_q last cycle
  logic                 comp_pend_q;   // completion seen during ISSUE

  logic                 rdy_match;
  logic                 rise;
  logic                 last_entry;
  logic [ITER_W:0]      iter_inc;
  logic [ITER_W:0]      iter_goal;
  logic [TMO_W-1:0]     wcnt_inc;
  logic [STAGE_W-1:0]   fetch_code;

  // Only a fresh match counts: a level that already matched is not a completion.
  assign rdy_match  = (stage_rdy == code_q);
  assign rise       = rdy_match && !prev_match_q;
  assign last_entry = ({1'b0, idx_q} == (len_q - 1'b1));
  assign iter_inc   = {1'b0, iter_q} + 1'b1;
  assign iter_goal  = (iter_num_q == '0) ? (ITER_W+1)'(1) : {1'b0, iter_num_q};
  assign wcnt_inc   = wcnt_q + 1'b1;
  assign fetch_code = table_q[idx_q];

  // Stage table: host writes accepted only while idle.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < SEQ_DEPTH; i++) table_q[i] <= '0;
    end else if (cfg_we && state_q == S_IDLE) begin
      table_q[cfg_addr] <= cfg_stage;
    end
  end

  // Sequencer FSM with registered outputs; abort overrides everything mid-run.
  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= S_IDLE;
      stage_val_q  <= '0;
      code_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      iter_q       <= '0;
      len_q        <= '0;
      iter_num_q   <= '0;
      loop_q       <= 1'b0;
      tmo_q        <= '0;
      wcnt_q       <= '0;
      pcnt_q       <= '0;
      prev_match_q <= 1'b0;
      comp_pend_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (abort && state_q != S_IDLE && state_q != S_FIN) begin
        stage_val_q <= '0;
        state_q     <= S_FIN;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && !abort) begin
              len_q      <= seq_len;
              iter_num_q <= iter_num;
              loop_q     <= loop_en;
              tmo_q      <= timeout_cyc;
              idx_q      <= '0;
              iter_q     <= '0;
              err_q      <= 1'b0;
              busy_q     <= 1'b1;
              state_q    <= (seq_len == '0) ? S_FIN : S_FETCH;
            end
          end
          S_FETCH: begin
            code_q       <= fetch_code;
            // Seed edge history with the current level so a stale match is ignored.
            prev_match_q <= (stage_rdy == fetch_code);
            comp_pend_q  <= 1'b0;
            pcnt_q       <= '0;
            if (fetch_code == '0) begin
              state_q <= S_NEXT;
            end else begin
              stage_val_q <= fetch_code;
              state_q     <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            prev_match_q <= rdy_match;
            if (rise) comp_pend_q <= 1'b1;
            if (pcnt_q == PCNT_W'(PULSE_LEN - 1)) begin
              stage_val_q <= '0;
              wcnt_q      <= '0;
              state_q     <= S_WAIT;
            end else begin
              pcnt_q <= pcnt_q + 1'b1;
            end
          end
          S_WAIT: begin
            prev_match_q <= rdy_match;
            wcnt_q       <= wcnt_inc;
            if (comp_pend_q || rise) begin
              state_q <= S_NEXT;
            end else if (tmo_q != '0 && wcnt_inc == tmo_q) begin
              err_q   <= 1'b1;
              state_q <= S_FIN;
            end
          end
          S_NEXT: begin
            if (last_entry) begin
              iter_q  <= iter_inc[ITER_W-1:0];
              idx_q   <= '0;
              state_q <= (!loop_q && iter_inc >= iter_goal) ? S_FIN : S_FETCH;
            end else begin
              idx_q   <= idx_q + 1'b1;
              state_q <= S_FETCH;
            end
          end
          S_FIN: begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign stage_val   = stage_val_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err_timeout = err_q;
  assign cur_idx     = idx_q;
  assign iter_cnt    = iter_q;

endmodule

// File: tb/tb_stage_sched.sv
// Testbench for stage_sched: directed run sequence with a scoreboard of
// expected issued codes and a simple Top responder model.
`timescale 1ns/1ps
module tb_stage_sched;
  localparam int STAGE_W   = 3;
  localparam int SEQ_AW    = 3;
  localparam int TMO_W     = 16;
  localparam int ITER_W    = 8;
  localparam int PULSE_LEN = 2;

  logic               clk = 1'b0;
  logic               sys_rst = 1'b1;
  logic               cfg_we = 1'b0;
  logic [SEQ_AW-1:0]  cfg_addr = '0;
  logic [STAGE_W-1:0] cfg_stage = '0;
  logic [SEQ_AW:0]    seq_len = '0;
  logic [ITER_W-1:0]  iter_num = '0;
  logic               loop_en = 1'b0;
  logic [TMO_W-1:0]   timeout_cyc = '0;
  logic               start = 1'b0;
  logic               abort = 1'b0;
  logic [STAGE_W-1:0] stage_rdy;
  logic [STAGE_W-1:0] stage_val;
  logic               busy;
  logic               done;
  logic               err_timeout;
  logic [SEQ_AW-1:0]  cur_idx;
  logic [ITER_W-1:0]  iter_cnt;

  stage_sched dut (
    .clk(clk), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_stage(cfg_stage), .seq_len(seq_len), .iter_num(iter_num),
    .loop_en(loop_en), .timeout_cyc(timeout_cyc), .start(start), .abort(abort),
    .stage_rdy(stage_rdy), .stage_val(stage_val), .busy(busy), .done(done),
    .err_timeout(err_timeout), .cur_idx(cur_idx), .iter_cnt(iter_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [STAGE_W-1:0] exp_q [$];

  // Monitor / Top-model state (written only by the monitor)
  int                 done_cnt = 0;
  int                 issue_cnt = 0;
  int                 pulse_len = 0;
  int                 model_timer = 0;
  logic [STAGE_W-1:0] prev_val = '0;
  logic [STAGE_W-1:0] model_code = '0;
  logic [STAGE_W-1:0] model_rdy = '0;
  logic [STAGE_W-1:0] exp_code;

  // Stimulus-side controls for the Top model
  logic               model_en = 1'b1;
  logic               resp_en = 1'b1;
  int                 resp_delay = 5;
  logic [STAGE_W-1:0] manual_rdy = '0;

  assign stage_rdy = model_en ? model_rdy : manual_rdy;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard monitor and Top responder, sampled 1ns after each edge.
  always @(posedge clk) begin
    #1;
    if (sys_rst) begin
      prev_val  = '0;
      pulse_len = 0;
      model_rdy = '0;
    end else begin
      if (done) done_cnt++;
      if (stage_val != '0 && prev_val == '0) begin
        issue_cnt++;
        exp_code = '0;
        if (exp_q.size() > 0) exp_code = exp_q.pop_front();
        check("issue_code", 32'(stage_val), 32'(exp_code));
        $display("issue #%0d code=%0d expected=%0d t=%0t", issue_cnt, stage_val, exp_code, $time);
        pulse_len   = 1;
        model_code  = stage_val;
        model_timer = 0;
        model_rdy   = '0;
      end else begin
        if (stage_val != '0) pulse_len++;
        else if (prev_val != '0) check("pulse_len", 32'(pulse_len), 32'(PULSE_LEN));
        model_timer++;
      end
      if (resp_en && model_timer == resp_delay) model_rdy = model_code;
      prev_val = stage_val;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input int addr, input int code);
    cfg_we    = 1'b1;
    cfg_addr  = SEQ_AW'(addr);
    cfg_stage = STAGE_W'(code);
    tick();
    cfg_we    = 1'b0;
  endtask

  task automatic go(input int len, input int iters, input logic lp, input int tmo);
    seq_len     = (SEQ_AW+1)'(len);
    iter_num    = ITER_W'(iters);
    loop_en     = lp;
    timeout_cyc = TMO_W'(tmo);
    start       = 1'b1;
    tick();
    start       = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 32'(done), 32'd1);
  endtask

  initial begin
    int base;
    int ibase;
    int n;

    // ---------------- reset state ----------------
    repeat (3) tick();
    check("rst_stage_val", 32'(stage_val), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_err", 32'(err_timeout), 0);
    check("rst_cur_idx", 32'(cur_idx), 0);
    check("rst_iter_cnt", 32'(iter_cnt), 0);
    sys_rst = 1'b0;
    tick();

    // ---------------- T1: [1,2,3,4], slow Top ----------------
    wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
    for (int i = 1; i <= 4; i++) exp_q.push_back(STAGE_W'(i));
    resp_delay = 600;
    base = done_cnt;
    go(4, 1, 1'b0, 0);
    check("t1_busy", 32'(busy), 1);
    check("t1_val_before_issue", 32'(stage_val), 0);
    tick();
    check("t1_first_issue", 32'(stage_val), 1);
    wait_done("t1_done", 3000);
    check("t1_iter_cnt", 32'(iter_cnt), 1);
    check("t1_err", 32'(err_timeout), 0);
    check("t1_done_count", 32'(done_cnt - base), 1);
    check("t1_queue_empty", 32'(exp_q.size()), 0);
    tick();
    check("t1_busy_after", 32'(busy), 0);
    check("t1_done_one_cycle", 32'(done), 0);

    // ---------------- T2: timeout ----------------
    wr(0, 4);
    exp_q.push_back(3'd4);
    resp_en = 1'b0;
    go(1, 1, 1'b0, 100);
    n = 0;
    while (stage_val != 3'd4 && n < 10) begin tick(); n++; end
    while (stage_val != 3'd0 && n < 20) begin tick(); n++; end
    n = 0;
    while (err_timeout !== 1'b1 && n < 300) begin tick(); n++; end
    check("t2_tmo_latency", 32'(n), 100);
    check("t2_busy_at_tmo", 32'(busy), 1);
    tick();
    check("t2_done", 32'(done), 1);
    check("t2_busy_after", 32'(busy), 0);
    resp_en = 1'b1;
    resp_delay = 5;
    exp_q.push_back(3'd4);
    go(1, 1, 1'b0, 0);
    check("t2_err_cleared", 32'(err_timeout), 0);
    wait_done("t2_rerun_done", 100);

    // ---------------- T3: [1,0,2] x3 ----------------
    wr(0, 1); wr(1, 0); wr(2, 2);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(3'd1);
      exp_q.push_back(3'd2);
    end
    resp_delay = 3;
    base = done_cnt;
    go(3, 3, 1'b0, 0);
    wait_done("t3_done", 500);
    check("t3_iter_cnt", 32'(iter_cnt), 3);
    check("t3_cur_idx", 32'(cur_idx), 0);
    check("t3_done_count", 32'(done_cnt - base), 1);
    check("t3_queue_empty", 32'(exp_q.size()), 0);

    // ---------------- T4: loop + abort ----------------
    wr(0, 3);
    for (int i = 0; i < 5; i++) exp_q.push_back(3'd3);
    resp_delay = 10;
    base  = done_cnt;
    ibase = issue_cnt;
    go(1, 1, 1'b1, 0);
    wr(0, 5);  // dropped: run in progress
    n = 0;
    while (!((issue_cnt - ibase) == 5 && stage_val == 3'd0) && n < 500) begin tick(); n++; end
    check("t4_reach_5th_wait", 32'(issue_cnt - ibase), 5);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t4_abort_val", 32'(stage_val), 0);
    check("t4_iter_cnt", 32'(iter_cnt), 4);
    tick();
    check("t4_done", 32'(done), 1);
    check("t4_busy_after", 32'(busy), 0);
    check("t4_done_count", 32'(done_cnt - base), 1);
    exp_q.push_back(3'd3);
    resp_delay = 4;
    go(1, 1, 1'b0, 0);
    wait_done("t4_rerun_done", 100);
    check("t4_table_kept", 32'(exp_q.size()), 0);

    // ---------------- T5: edge-based completion ----------------
    model_en   = 1'b0;
    manual_rdy = 3'd2;
    wr(0, 2);
    exp_q.push_back(3'd2);
    base = done_cnt;
    go(1, 1, 1'b0, 0);
    repeat (12) tick();
    check("t5_no_premature_busy", 32'(busy), 1);
    check("t5_no_premature_done", 32'(done_cnt - base), 0);
    manual_rdy = 3'd0;
    tick();
    tick();
    manual_rdy = 3'd2;
    wait_done("t5_reedge_done", 10);
    manual_rdy = 3'd0;
    exp_q.push_back(3'd2);
    go(1, 1, 1'b0, 0);
    n = 0;
    while (stage_val != 3'd2 && n < 10) begin tick(); n++; end
    manual_rdy = 3'd2;
    n = 0;
    while (done !== 1'b1 && n < 20) begin tick(); n++; end
    check("t5_issue_comp_latency", 32'(n), 5);
    manual_rdy = 3'd0;
    model_en   = 1'b1;

    // ---------------- T6: reset mid-issue, empty sequence ----------------
    resp_delay = 50;
    wr(0, 1);
    exp_q.push_back(3'd1);
    go(1, 1, 1'b0, 0);
    tick();
    check("t6_issuing", 32'(stage_val), 1);
    sys_rst = 1'b1;
    #1;
    check("t6_rst_stage_val", 32'(stage_val), 0);
    check("t6_rst_busy", 32'(busy), 0);
    check("t6_rst_done", 32'(done), 0);
    check("t6_rst_cur_idx", 32'(cur_idx), 0);
    check("t6_rst_iter_cnt", 32'(iter_cnt), 0);
    base = done_cnt;
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    check("t6_no_done", 32'(done_cnt - base), 0);
    ibase = issue_cnt;
    go(0, 1, 1'b0, 0);
    check("t6_len0_no_early_done", 32'(done), 0);
    tick();
    check("t6_len0_done", 32'(done), 1);
    check("t6_len0_no_issue", 32'(issue_cnt - ibase), 0);
    tick();
    check("t6_len0_busy_after", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
